// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared types and constants for the multiplexed
// seven-segment scan driver.
//   scan_e    - scan FSM state encoding (off / dead-time / digit on)
//   seg_blank - returns a mask of w ones; used to build the all-off segment
//               byte (segments are active-low, so all ones = dark)
package seg_scan_pkg;

  typedef enum logic [1:0] {
    SCAN_OFF  = 2'd0,
    SCAN_DEAD = 2'd1,
    SCAN_ON   = 2'd2
  } scan_e;

  localparam int SEG_W_MAX = 64;

  function automatic logic [SEG_W_MAX-1:0] seg_blank(input int w);
    logic [SEG_W_MAX-1:0] m;
    m = '0;
    for (int i = 0; i < SEG_W_MAX; i++) begin
      if (i < w) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/seg_scan_if.sv
// seg_scan_if: signal bundle between the time-keeping counter and the scan
// driver, plus the display-side outputs.
//   seg_in     - DIGITS packed segment bytes, digit i at [i*SEG_W +: SEG_W]
//   in_valid   - capture strobe for seg_in
//   blank      - level, 1 forces the display dark
//   blink_mask - digits to blink (only when SEG_SCAN_BLINK_EN is defined)
//   an_out     - active-low digit enables
//   seg_out    - active-low shared segment bus
//   frame_done - one-cycle pulse at the end of each scan frame
// Modports: master = producer/display side, slave = scan driver.
interface seg_scan_if #(
  parameter int DIGITS = 6,
  parameter int SEG_W  = 8
);
  logic [DIGITS*SEG_W-1:0] seg_in;
  logic                    in_valid;
  logic                    blank;
`ifdef SEG_SCAN_BLINK_EN
  logic [DIGITS-1:0]       blink_mask;
`endif
  logic [DIGITS-1:0]       an_out;
  logic [SEG_W-1:0]        seg_out;
  logic                    frame_done;

`ifdef SEG_SCAN_BLINK_EN
  modport master (output seg_in, in_valid, blank, blink_mask,
                  input  an_out, seg_out, frame_done);
  modport slave  (input  seg_in, in_valid, blank, blink_mask,
                  output an_out, seg_out, frame_done);
`else
  modport master (output seg_in, in_valid, blank,
                  input  an_out, seg_out, frame_done);
  modport slave  (input  seg_in, in_valid, blank,
                  output an_out, seg_out, frame_done);
`endif
endinterface

// File: rtl/seg_scan_timer.sv
// seg_scan_timer: slot position counter for the scan driver.
// Counts 0..SCAN_DIV-1 and wraps; clr forces it to 0 on the next edge.
//   clk - clock, rst - asynchronous active-low reset
//   clr - synchronous clear
//   cnt - current position within the slot
//   tc  - high while cnt == SCAN_DIV-1
module seg_scan_timer #(
  parameter  int SCAN_DIV = 1000,
  localparam int CNT_W    = $clog2(SCAN_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_reg;

  assign tc  = (cnt_reg == CNT_W'(SCAN_DIV - 1));
  assign cnt = cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (clr || tc) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan.sv
// seg_scan: multiplexed seven-segment display driver.
// Scans DIGITS digits one slot at a time (SCAN_DIV cycles per slot, the
// first DEAD cycles of each slot dark), double-buffering the input bytes so
// a frame never mixes two time values.
// Ports:
//   clk - clock (rising edge)
//   rst - asynchronous active-low reset
//   bus - seg_scan_if.slave: seg_in/in_valid/blank[/blink_mask] in,
//         an_out/seg_out/frame_done out (all outputs registered)
// Optional feature: define SEG_SCAN_BLINK_EN to add blink_mask and the
// frame-count blink phase; otherwise no digit ever blinks.
module seg_scan
  import seg_scan_pkg::*;
#(
  parameter int DIGITS       = 6,
  parameter int SEG_W        = 8,
  parameter int SCAN_DIV     = 1000,
  parameter int DEAD         = 2,
  parameter int BLINK_FRAMES = 64
) (
  input logic       clk,
  input logic       rst,
  seg_scan_if.slave bus
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int DIG_W = $clog2(DIGITS);
  localparam logic [SEG_W-1:0] SEG_BLANK = SEG_W'(seg_blank(SEG_W));

  scan_e                        state_reg, state_next;
  logic [DIG_W-1:0]             digit_reg, digit_next;
  logic [CNT_W-1:0]             cnt;
  logic                         tc;
  logic                         timer_clr;

  logic [DIGITS-1:0][SEG_W-1:0] seg_in_a;
  logic [DIGITS-1:0][SEG_W-1:0] pending_reg;
  logic [DIGITS-1:0][SEG_W-1:0] active_reg, active_next;
  logic                         pend_vld_reg, pend_vld_next;
  logic                         transfer;

  logic [DIGITS-1:0]            an_reg, an_next;
  logic [SEG_W-1:0]             seg_reg, seg_next;
  logic                         fd_reg, fd_next;
  logic                         hide;

  assign seg_in_a = bus.seg_in;

  // Slot counter is held at 0 while off and restarts from 0 on blank.
  assign timer_clr = bus.blank || (state_reg == SCAN_OFF);

  seg_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (timer_clr),
    .cnt (cnt),
    .tc  (tc)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= SCAN_OFF;
      digit_reg <= '0;
    end else begin
      state_reg <= state_next;
      digit_reg <= digit_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    digit_next = digit_reg;
    if (bus.blank) begin
      state_next = SCAN_OFF;
      digit_next = '0;
    end else begin
      case (state_reg)
        SCAN_OFF: begin
          state_next = SCAN_DEAD;
          digit_next = '0;
        end
        SCAN_DEAD: begin
          if (cnt == CNT_W'(DEAD - 1)) state_next = SCAN_ON;
        end
        SCAN_ON: begin
          if (tc) begin
            state_next = SCAN_DEAD;
            digit_next = (digit_reg == DIG_W'(DIGITS - 1)) ? '0 : digit_reg + 1'b1;
          end
        end
        default: begin
          state_next = SCAN_OFF;
          digit_next = '0;
        end
      endcase
    end
  end

  // ---------------- input double buffer ----------------
  // Active only changes at a frame boundary or while dark, so one frame
  // always shows one captured value. A strobe on the transfer cycle itself
  // bypasses the pending buffer.
  assign transfer = fd_reg || (state_reg == SCAN_OFF);

  always_comb begin
    active_next   = active_reg;
    pend_vld_next = pend_vld_reg | bus.in_valid;
    if (transfer) begin
      if (bus.in_valid)      active_next = seg_in_a;
      else if (pend_vld_reg) active_next = pending_reg;
      pend_vld_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_reg  <= {DIGITS{SEG_BLANK}};
      active_reg   <= {DIGITS{SEG_BLANK}};
      pend_vld_reg <= 1'b0;
    end else begin
      if (bus.in_valid) pending_reg <= seg_in_a;
      active_reg   <= active_next;
      pend_vld_reg <= pend_vld_next;
    end
  end

  // ---------------- optional blink ----------------
`ifdef SEG_SCAN_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FC_W-1:0] fcnt_reg;
  logic            phase_reg;

  // Phase flips every BLINK_FRAMES completed frames. It settles on the
  // frame-boundary edge, which always precedes the next ON cycle by at
  // least one dead cycle, so using the registered value is safe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fcnt_reg  <= '0;
      phase_reg <= 1'b0;
    end else if (state_reg == SCAN_OFF) begin
      fcnt_reg  <= '0;
      phase_reg <= 1'b0;
    end else if (fd_reg) begin
      if (fcnt_reg == FC_W'(BLINK_FRAMES - 1)) begin
        fcnt_reg  <= '0;
        phase_reg <= ~phase_reg;
      end else begin
        fcnt_reg <= fcnt_reg + 1'b1;
      end
    end
  end

  assign hide = phase_reg && bus.blink_mask[digit_next];
`else
  assign hide = 1'b0;
`endif

  // ---------------- FSM: outputs (from next state) ----------------
  always_comb begin
    seg_next = SEG_BLANK;
    if ((state_next == SCAN_ON) && !hide) seg_next = active_next[digit_next];
    // The pulse marks the terminal-count cycle of the last digit; register
    // it one cycle early, when the counter is one short of terminal.
    fd_next = (state_next == SCAN_ON) &&
              (digit_next == DIG_W'(DIGITS - 1)) &&
              (cnt == CNT_W'(SCAN_DIV - 2));
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_an
    assign an_next[gi] = !((state_next == SCAN_ON) && (digit_next == DIG_W'(gi)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_reg  <= '1;
      seg_reg <= SEG_BLANK;
      fd_reg  <= 1'b0;
    end else begin
      an_reg  <= an_next;
      seg_reg <= seg_next;
      fd_reg  <= fd_next;
    end
  end

  assign bus.an_out     = an_reg;
  assign bus.seg_out    = seg_reg;
  assign bus.frame_done = fd_reg;

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: self-checking bench for seg_scan (DIGITS=6, SCAN_DIV=4,
// DEAD=1, BLINK_FRAMES=2). A time-based reference model (cycles since the
// display was unblanked) predicts the outputs every cycle; scripted
// sequences pin the model with hand-computed values; a random phase
// exercises strobes, blanking and blink masks.
`timescale 1ns/1ps
module tb_seg_scan;

  localparam int DIGITS       = 6;
  localparam int SEG_W        = 8;
  localparam int SCAN_DIV     = 4;
  localparam int DEAD         = 1;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = DIGITS * SCAN_DIV;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seg_scan_if #(.DIGITS(DIGITS), .SEG_W(SEG_W)) bus ();

  seg_scan #(
    .DIGITS(DIGITS), .SEG_W(SEG_W), .SCAN_DIV(SCAN_DIV),
    .DEAD(DEAD), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  logic [SEG_W-1:0]  m_active  [DIGITS];
  logic [SEG_W-1:0]  m_pending [DIGITS];
  bit                m_pvld;
  int                m_t = -1;   // cycles since unblank; -1 = dark
  bit                m_fd;
  logic [DIGITS-1:0] m_an;
  logic [SEG_W-1:0]  m_seg;
  logic [DIGITS-1:0] mask_now;

`ifdef SEG_SCAN_BLINK_EN
  assign mask_now = bus.blink_mask;
`else
  assign mask_now = '0;
`endif

  always @(posedge clk or negedge rst) begin
    bit xfer;
    int slot;
    int off;
    bit phase;
    if (!rst) begin
      for (int i = 0; i < DIGITS; i++) begin
        m_active[i]  = '1;
        m_pending[i] = '1;
      end
      m_pvld = 1'b0;
      m_t    = -1;
      m_fd   = 1'b0;
      m_an   = '1;
      m_seg  = '1;
    end else begin
      xfer = (m_t < 0) || m_fd;
      for (int i = 0; i < DIGITS; i++) begin
        if (xfer) begin
          if (bus.in_valid) m_active[i] = bus.seg_in[i*SEG_W +: SEG_W];
          else if (m_pvld)  m_active[i] = m_pending[i];
        end
        if (bus.in_valid) m_pending[i] = bus.seg_in[i*SEG_W +: SEG_W];
      end
      m_pvld = xfer ? 1'b0 : (m_pvld | bus.in_valid);
      m_t    = bus.blank ? -1 : m_t + 1;
      m_an   = '1;
      m_seg  = '1;
      m_fd   = 1'b0;
      if (m_t >= 0) begin
        slot  = (m_t / SCAN_DIV) % DIGITS;
        off   = m_t % SCAN_DIV;
        phase = (((m_t / FRAME) / BLINK_FRAMES) % 2) == 1;
        if (off >= DEAD) begin
          m_an[slot] = 1'b0;
          m_seg      = (phase && mask_now[slot]) ? '1 : m_active[slot];
          m_fd       = (slot == DIGITS - 1) && (off == SCAN_DIV - 1);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #1;
    if (cmp_en && rst) begin
      chk("model_an_out",     32'(bus.an_out),     32'(m_an));
      chk("model_seg_out",    32'(bus.seg_out),    32'(m_seg));
      chk("model_frame_done", 32'(bus.frame_done), 32'(m_fd));
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.seg_in   = '1;
    bus.in_valid = 1'b0;
    bus.blank    = 1'b1;
`ifdef SEG_SCAN_BLINK_EN
    bus.blink_mask = '0;
`endif
    rst = 1'b0;
    #23;
    chk("reset_an",  32'(bus.an_out),     'h3F);
    chk("reset_seg", 32'(bus.seg_out),    'hFF);
    chk("reset_fd",  32'(bus.frame_done), 'h0);
    @(negedge clk);
    rst    = 1'b1;
    cmp_en = 1'b1;

    // Blank held: display dark throughout.
    repeat (10) begin
      step();
      chk("blank_an",  32'(bus.an_out),     'h3F);
      chk("blank_seg", 32'(bus.seg_out),    'hFF);
      chk("blank_fd",  32'(bus.frame_done), 'h0);
    end

    // Load C0+i while dark, then unblank.
    for (int i = 0; i < DIGITS; i++) bus.seg_in[i*SEG_W +: SEG_W] = 8'hC0 + 8'(i);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    bus.blank = 1'b0;
    step();                                        // c=1
    chk("first_dead_an", 32'(bus.an_out), 'h3F);
    step();                                        // c=2
    chk("d0_an",  32'(bus.an_out),  'h3E);
    chk("d0_seg", 32'(bus.seg_out), 'hC0);
    step(); step();                                // c=4
    chk("d0_last_an", 32'(bus.an_out), 'h3E);
    step();                                        // c=5
    chk("d1_dead_an",  32'(bus.an_out),  'h3F);
    chk("d1_dead_seg", 32'(bus.seg_out), 'hFF);
    step();                                        // c=6
    chk("d1_an",  32'(bus.an_out),  'h3D);
    chk("d1_seg", 32'(bus.seg_out), 'hC1);
    repeat (17) step();                            // c=23
    chk("fd_c23", 32'(bus.frame_done), 'h0);
    step();                                        // c=24
    chk("fd_c24", 32'(bus.frame_done), 'h1);

    // Mid-frame strobe: old bytes stay for the rest of the frame.
    repeat (5) step();                             // c=29
    for (int i = 0; i < DIGITS; i++) bus.seg_in[i*SEG_W +: SEG_W] = 8'hF9;
    bus.in_valid = 1'b1;
    step();                                        // c=30
    bus.in_valid = 1'b0;
    chk("mid_keep_old_seg", 32'(bus.seg_out), 'hC1);
    repeat (20) step();                            // c=50
    chk("next_frame_new_seg", 32'(bus.seg_out), 'hF9);

    // Strobe on the frame_done cycle: bypass into the next frame.
    repeat (22) step();                            // c=72
    chk("fd_c72", 32'(bus.frame_done), 'h1);
    for (int i = 0; i < DIGITS; i++) bus.seg_in[i*SEG_W +: SEG_W] = 8'h92;
    bus.in_valid = 1'b1;
    step();                                        // c=73
    bus.in_valid = 1'b0;
    step();                                        // c=74
    chk("bypass_seg", 32'(bus.seg_out), 'h92);

    // Blank during digit 3 ON, then restart from digit 0.
    repeat (12) step();                            // c=86
    chk("d3_an", 32'(bus.an_out), 'h37);
    bus.blank = 1'b1;
    step();
    chk("blank_mid_an",  32'(bus.an_out),  'h3F);
    chk("blank_mid_seg", 32'(bus.seg_out), 'hFF);
    step(); step();
    chk("blank_mid_fd", 32'(bus.frame_done), 'h0);
    bus.blank = 1'b0;
    step();
    chk("restart_dead_an", 32'(bus.an_out), 'h3F);
    step();
    chk("restart_d0_an",  32'(bus.an_out),  'h3E);
    chk("restart_d0_seg", 32'(bus.seg_out), 'h92);

    // Blink on digit 2 from a fresh scan start.
    bus.blank = 1'b1;
    step();
`ifdef SEG_SCAN_BLINK_EN
    bus.blink_mask = 6'b000100;
`endif
    bus.blank = 1'b0;
    repeat (10) step();                            // c=10, frame 1
    chk("blink_f1_an",  32'(bus.an_out),  'h3B);
    chk("blink_f1_seg", 32'(bus.seg_out), 'h92);
    repeat (48) step();                            // c=58, frame 3
    chk("blink_f3_an", 32'(bus.an_out), 'h3B);
`ifdef SEG_SCAN_BLINK_EN
    chk("blink_f3_seg", 32'(bus.seg_out), 'hFF);
`else
    chk("blink_f3_seg", 32'(bus.seg_out), 'h92);
`endif
    repeat (48) step();                            // c=106, frame 5
    chk("blink_f5_seg", 32'(bus.seg_out), 'h92);

    // Random traffic checked by the model.
    for (int k = 0; k < 1500; k++) begin
      bus.in_valid = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < DIGITS; i++) bus.seg_in[i*SEG_W +: SEG_W] = 8'($urandom);
      if (bus.blank) bus.blank = ($urandom_range(0, 9) < 7);
      else           bus.blank = ($urandom_range(0, 199) == 0);
`ifdef SEG_SCAN_BLINK_EN
      if ($urandom_range(0, 149) == 0) bus.blink_mask = 6'($urandom);
`endif
      step();
    end
    bus.blank    = 1'b0;
    bus.in_valid = 1'b0;
    repeat (30) step();

    // Asynchronous reset mid-slot: outputs drop with no clock edge.
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_an",  32'(bus.an_out),     'h3F);
    chk("async_rst_seg", 32'(bus.seg_out),    'hFF);
    chk("async_rst_fd",  32'(bus.frame_done), 'h0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("post_rst_dead_an", 32'(bus.an_out), 'h3F);
    step();
    chk("post_rst_d0_an",  32'(bus.an_out),  'h3E);
    chk("post_rst_d0_seg", 32'(bus.seg_out), 'hFF);
    repeat (60) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
# seg_scan

Multiplexed seven-segment display driver that sits directly downstream of the time-keeping counter. It accepts the six per-digit segment bytes the counter produces in parallel and drives one shared segment bus plus per-digit enables. Digits are scanned one slot at a time, with dead-time between slots to suppress ghosting. Input bytes are double-buffered so the display never mixes two different time values within one frame.

## Interface
- `DIGITS`, 6, number of digits scanned (≥2).
- `SEG_W`, 8, segment byte width (7 segments + dp).
- `SCAN_DIV`, 1000, clk cycles per digit slot (≥2).
- `DEAD`, 2, leading cycles of each slot with all digits off (1 ≤ DEAD < SCAN_DIV).
- `BLINK_FRAMES`, 64, frames per blink half-period (only with `SEG_SCAN_BLINK_EN`).

Ports:
- `clk` in 1: single clock; all state is on its rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `seg_in` in DIGITS*SEG_W: segment bytes; digit i occupies `[i*SEG_W +: SEG_W]`; bytes are active-low (0 = segment lit).
- `in_valid` in 1: capture strobe for `seg_in`.
- `blank` in 1: level; 1 forces the display off.
- `blink_mask` in DIGITS: digits to blink (only with `SEG_SCAN_BLINK_EN`).
- `an_out` out DIGITS: digit enables, active-low, at most one bit low at a time.
- `seg_out` out SEG_W: shared segment bus, active-low.
- `frame_done` out 1: one-cycle pulse at the end of each full scan frame.

## Operation
- Buffers:
  - `pending` holds the latest `seg_in`. It is loaded on any cycle with `in_valid=1`, which also sets `pend_vld`.
  - `active` drives the display.
- Transfer: on a frame boundary (the `frame_done` cycle), or on any cycle in OFF:
  - if `in_valid=1`, `active` loads `seg_in` directly (bypass);
  - otherwise, if `pend_vld=1`, `active` loads `pending`.
  - `pend_vld` clears in either case.
- FSM states: OFF, DEAD, ON.
  - Reset → OFF.
  - OFF & !blank → DEAD, with `digit`=0 and `cnt`=0.
  - DEAD & cnt==DEAD-1 → ON.
  - ON & cnt==SCAN_DIV-1 → DEAD, with `digit` = (digit==DIGITS-1) ? 0 : digit+1.
  - Any state & blank → OFF. Blank wins over every other transition. `digit` and `cnt` return to 0.
- `cnt` runs 0..SCAN_DIV-1 through each slot: DEAD covers cnt 0..DEAD-1, ON covers DEAD..SCAN_DIV-1. `cnt` is held at 0 in OFF.
- Outputs:
  - In ON: `an_out` has only bit `digit` low; `seg_out` = `active[digit]`.
  - In DEAD and OFF: `an_out` all 1s, `seg_out` = all 1s.
- `frame_done`: asserted while in ON with digit==DIGITS-1 and cnt==SCAN_DIV-1. It is never asserted in OFF.

## Timing
- Reset values:
  - `an_out` all 1s; `seg_out` all 1s; `frame_done` 0.
  - `active` and `pending` all 1s; `pend_vld` 0.
  - State OFF; `cnt` 0; `digit` 0.
- `an_out`, `seg_out` and `frame_done` are registered. They are computed from next-state, so they change on the same edge as the state/cnt they reflect.
- Slot length = SCAN_DIV cycles; digit-on time = SCAN_DIV-DEAD cycles; frame = DIGITS*SCAN_DIV cycles.
- blank deasserted before edge k:
  - DEAD from edge k;
  - first `an_out[0]` low from edge k+DEAD.
- blank asserted before edge k: outputs are off from edge k, regardless of position in the slot.
- `in_valid` mid-frame: the new value appears at the first ON slot after the next frame boundary. A frame never mixes two values.
- `in_valid` on multiple cycles within one frame: last value wins.
- Asynchronous reset mid-slot: outputs go to reset values immediately, with no clock required.

## Configuration
- `SEG_SCAN_BLINK_EN` defined:
  - `blink_mask` port and a frame counter exist.
  - `phase` toggles after every BLINK_FRAMES `frame_done` pulses. `phase` and the frame counter reset to 0, and are cleared in OFF.
  - While `phase`=1, ON slots of digits with `blink_mask[digit]=1` drive `seg_out` all 1s. `an_out` is still asserted.
- Not defined: no port, no counter; behaviour equals `blink_mask`=0.

## Structure
- `seg_scan_pkg`: `scan_e` enum {OFF, DEAD, ON} (logic [1:0]); `SEG_BLANK` constant (all 1s, SEG_W-wide via parameterised function).
- One sub-module, `seg_scan_timer`: counter with synchronous clear and a SCAN_DIV-1 terminal-count output. It drives `cnt`.
- Top holds the FSM, buffers, output registers and the optional blink logic.

## Test plan
Parameters: DIGITS=6, SCAN_DIV=4, DEAD=1, BLINK_FRAMES=2 unless stated.
- Reset with blank=1, held 10 cycles → `an_out`=6'b111111, `seg_out`=8'hFF, `frame_done`=0 throughout.
- Load byte i=8'h(C0+i) with in_valid in OFF, then blank=0 → `an_out[0]` low at cycle 1 after DEAD for 3 cycles with `seg_out`=8'hC0; off 1 cycle; `an_out[1]` low 3 cycles with 8'hC1; `frame_done` pulses every 24 cycles.
- in_valid with all bytes 8'hF9 at cycle 5 of a frame → remaining slots keep the old bytes; the next frame shows 8'hF9 on every digit.
- in_valid exactly on the `frame_done` cycle with bytes 8'h92 → the next frame's digit 0 shows 8'h92 (bypass).
- blank=1 during digit 3's ON phase → all off next edge; on blank=0, restart at digit 0 after 1 dead cycle; `frame_done` not pulsed for the aborted frame.
- `SEG_SCAN_BLINK_EN`, `blink_mask`=6'b000100 → digit 2 shows `seg_out`=8'hFF during frames 3–4, 7–8, …; other digits are unaffected; `an_out[2]` is still pulsed.
